// File: rtl/rand_seq_scheduler.sv
// rand_seq_scheduler: round-robin sharing of one 3-bit pseudo-random
// sequence generator between two burst requesters.
module rand_seq_scheduler #(
    parameter int STEP_DIV = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] req,
    input  logic [1:0] mode,
    input  logic [2:0] len0,
    input  logic [2:0] len1,
    output logic [1:0] gnt,
    output logic [2:0] q,
    output logic [2:0] qbar,
    output logic       vld,
    output logic       owner,
    output logic       done,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] DIV_LAST = 4'(STEP_DIV - 1);

    state_t     state_q, state_d;
    logic       rr_q, rr_d;
    logic [2:0] step_q, step_d;
    logic [3:0] div_q, div_d;
    logic [2:0] len_q, len_d;
    logic       mode_q, mode_d;
    logic [1:0] gnt_q, gnt_d;
    logic [2:0] q_q, q_d;
    logic       vld_q, vld_d;
    logic       done_q, done_d;
    logic       owner_q, owner_d;
    logic       busy_q, busy_d;

    logic       win;
    logic [2:0] win_len;
    logic       win_mode;

    function automatic logic [2:0] next_a(input logic [2:0] v);
        logic [2:0] r;
        case (v)
            3'd0:    r = 3'd4;
            3'd4:    r = 3'd7;
            3'd7:    r = 3'd2;
            3'd2:    r = 3'd3;
            3'd3:    r = 3'd0;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] next_b(input logic [2:0] v);
        logic [2:0] r;
        case (v)
            3'd1:    r = 3'd4;
            3'd4:    r = 3'd3;
            3'd3:    r = 3'd5;
            3'd5:    r = 3'd7;
            3'd7:    r = 3'd6;
            3'd6:    r = 3'd2;
            3'd2:    r = 3'd1;
            default: r = 3'd1;
        endcase
        return r;
    endfunction

    // Contention goes to the rr pointer; a lone requester always wins.
    assign win      = (req == 2'b11) ? rr_q : req[1];
    assign win_len  = win ? len1 : len0;
    assign win_mode = mode[win];

    assign gnt   = gnt_q;
    assign q     = q_q;
    assign qbar  = ~q_q;
    assign vld   = vld_q;
    assign done  = done_q;
    assign owner = owner_q;
    assign busy  = busy_q;

    // Next-state and datapath: grant, step, complete or abort a burst.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        step_d  = step_q;
        div_d   = div_q;
        len_d   = len_q;
        mode_d  = mode_q;
        gnt_d   = gnt_q;
        q_d     = q_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (busy_q) begin
                    // Cycle after done: release grant, forcing one idle cycle.
                    gnt_d  = 2'b00;
                    busy_d = 1'b0;
                    rr_d   = ~owner_q;
                end else if (|req) begin
                    gnt_d   = win ? 2'b10 : 2'b01;
                    owner_d = win;
                    busy_d  = 1'b1;
                    mode_d  = win_mode;
                    len_d   = win_len;
                    q_d     = win_mode ? 3'd1 : 3'd0;
                    vld_d   = 1'b1;
                    step_d  = 3'd0;
                    div_d   = 4'd0;
                    if (win_len == 3'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    busy_d  = 1'b0;
                    rr_d    = ~owner_q;
                end else if (div_q == DIV_LAST) begin
                    div_d  = 4'd0;
                    q_d    = mode_q ? next_b(q_q) : next_a(q_q);
                    vld_d  = 1'b1;
                    step_d = step_q + 3'd1;
                    if (step_q + 3'd1 == len_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    div_d = div_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously by clr.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            step_q  <= 3'd0;
            div_q   <= 4'd0;
            len_q   <= 3'd0;
            mode_q  <= 1'b0;
            gnt_q   <= 2'b00;
            q_q     <= 3'd0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            owner_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            step_q  <= step_d;
            div_q   <= div_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_rand_seq_scheduler.sv
// Directed bench for rand_seq_scheduler: STEP_DIV=1 and STEP_DIV=3
// instances, hand-computed expectations checked by immediate assertions.
module tb_rand_seq_scheduler;

    logic       clk = 1'b0;
    logic       clr = 1'b0;

    logic [1:0] req = 2'b00, mode = 2'b00;
    logic [2:0] len0 = 3'd0, len1 = 3'd0;
    logic [1:0] gnt;
    logic [2:0] q, qbar;
    logic       vld, owner, done, busy;

    logic [1:0] req3 = 2'b00, mode3 = 2'b00;
    logic [2:0] len03 = 3'd0, len13 = 3'd0;
    logic [1:0] gnt3;
    logic [2:0] q3, qbar3;
    logic       vld3, owner3, done3, busy3;

    int errors = 0;
    int checks = 0;

    rand_seq_scheduler #(.STEP_DIV(1)) dut (
        .clk(clk), .clr(clr), .req(req), .mode(mode),
        .len0(len0), .len1(len1), .gnt(gnt), .q(q), .qbar(qbar),
        .vld(vld), .owner(owner), .done(done), .busy(busy)
    );

    rand_seq_scheduler #(.STEP_DIV(3)) dut3 (
        .clk(clk), .clr(clr), .req(req3), .mode(mode3),
        .len0(len03), .len1(len13), .gnt(gnt3), .q(q3), .qbar(qbar3),
        .vld(vld3), .owner(owner3), .done(done3), .busy(busy3)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] seq_a [5];
        logic [2:0] seq_b [8];
        logic       dv_vld [7];
        logic [2:0] dv_q [7];
        seq_a = '{3'd0, 3'd4, 3'd7, 3'd2, 3'd3};
        seq_b = '{3'd1, 3'd4, 3'd3, 3'd5, 3'd7, 3'd6, 3'd2, 3'd1};
        dv_vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        dv_q = '{3'd0, 3'd0, 3'd0, 3'd4, 3'd4, 3'd4, 3'd7};

        // reset values
        tick();
        chk("rst_gnt", 8'(gnt), 8'h0);
        chk("rst_q", 8'(q), 8'h0);
        chk("rst_qbar", 8'(qbar), 8'h7);
        chk("rst_vld", 8'(vld), 8'h0);
        chk("rst_done", 8'(done), 8'h0);
        chk("rst_busy", 8'(busy), 8'h0);
        chk("rst_owner", 8'(owner), 8'h0);
        clr = 1'b1;

        // single A burst, 5 values
        req = 2'b01; mode = 2'b00; len0 = 3'd4;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("a_q%0d", k), 8'(q), 8'(seq_a[k]));
            chk($sformatf("a_vld%0d", k), 8'(vld), 8'h1);
            chk($sformatf("a_gnt%0d", k), 8'(gnt), 8'h1);
            chk($sformatf("a_done%0d", k), 8'(done), 8'(k == 4));
        end
        chk("a_qbar", 8'(qbar), 8'h4);
        req = 2'b00;
        tick();
        chk("a_gnt_end", 8'(gnt), 8'h0);
        chk("a_busy_end", 8'(busy), 8'h0);
        chk("a_vld_end", 8'(vld), 8'h0);

        // single B burst, 8 values
        req = 2'b10; mode = 2'b10; len1 = 3'd7;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("b_q%0d", k), 8'(q), 8'(seq_b[k]));
            chk($sformatf("b_vld%0d", k), 8'(vld), 8'h1);
            chk($sformatf("b_owner%0d", k), 8'(owner), 8'h1);
            chk($sformatf("b_done%0d", k), 8'(done), 8'(k == 7));
        end
        req = 2'b00;
        tick();
        chk("b_gnt_end", 8'(gnt), 8'h0);
        chk("b_owner_hold", 8'(owner), 8'h1);

        // contention: 01, idle, 10, idle, 01
        req = 2'b11; mode = 2'b00; len0 = 3'd1; len1 = 3'd1;
        tick();
        chk("c1_gnt", 8'(gnt), 8'h1);
        chk("c1_q0", 8'(q), 8'h0);
        tick();
        chk("c1_q1", 8'(q), 8'h4);
        chk("c1_done", 8'(done), 8'h1);
        tick();
        chk("c1_idle", 8'(gnt), 8'h0);
        chk("c1_idle_vld", 8'(vld), 8'h0);
        tick();
        chk("c2_gnt", 8'(gnt), 8'h2);
        chk("c2_q0", 8'(q), 8'h0);
        chk("c2_owner", 8'(owner), 8'h1);
        tick();
        chk("c2_q1", 8'(q), 8'h4);
        chk("c2_done", 8'(done), 8'h1);
        tick();
        chk("c2_idle", 8'(gnt), 8'h0);
        tick();
        chk("c3_gnt", 8'(gnt), 8'h1);
        chk("c3_q0", 8'(q), 8'h0);
        tick();
        chk("c3_q1", 8'(q), 8'h4);
        chk("c3_done", 8'(done), 8'h1);
        req = 2'b00;
        tick();
        chk("c3_idle", 8'(gnt), 8'h0);

        // abort after the 2nd value of a 6-value burst
        req = 2'b01; len0 = 3'd5;
        tick();
        chk("ab_gnt", 8'(gnt), 8'h1);
        chk("ab_q0", 8'(q), 8'h0);
        tick();
        chk("ab_q1", 8'(q), 8'h4);
        chk("ab_vld1", 8'(vld), 8'h1);
        req = 2'b00;
        tick();
        chk("ab_gnt_off", 8'(gnt), 8'h0);
        chk("ab_vld_off", 8'(vld), 8'h0);
        chk("ab_done_off", 8'(done), 8'h0);
        chk("ab_q_hold", 8'(q), 8'h4);
        chk("ab_busy_off", 8'(busy), 8'h0);
        tick();
        chk("ab_quiet_vld", 8'(vld), 8'h0);
        chk("ab_quiet_done", 8'(done), 8'h0);
        req = 2'b11;
        tick();
        chk("ab_next_gnt", 8'(gnt), 8'h2);
        chk("ab_next_owner", 8'(owner), 8'h1);
        tick();
        chk("ab_next_done", 8'(done), 8'h1);
        req = 2'b00;
        tick();

        // divider STEP_DIV=3, 3 values
        req3 = 2'b01; mode3 = 2'b00; len03 = 3'd2;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("d_vld%0d", k), 8'(vld3), 8'(dv_vld[k]));
            chk($sformatf("d_q%0d", k), 8'(q3), 8'(dv_q[k]));
            chk($sformatf("d_gnt%0d", k), 8'(gnt3), 8'h1);
            chk($sformatf("d_done%0d", k), 8'(done3), 8'(k == 6));
        end
        req3 = 2'b00;
        tick();
        chk("d_gnt_end", 8'(gnt3), 8'h0);

        // reset mid-burst, then restart from the seed
        req = 2'b10; mode = 2'b10; len1 = 3'd7;
        tick();
        chk("r_gnt", 8'(gnt), 8'h2);
        chk("r_q0", 8'(q), 8'h1);
        tick();
        chk("r_q1", 8'(q), 8'h4);
        #2 clr = 1'b0;
        #1;
        chk("r_gnt_rst", 8'(gnt), 8'h0);
        chk("r_q_rst", 8'(q), 8'h0);
        chk("r_qbar_rst", 8'(qbar), 8'h7);
        chk("r_busy_rst", 8'(busy), 8'h0);
        chk("r_vld_rst", 8'(vld), 8'h0);
        chk("r_done_rst", 8'(done), 8'h0);
        #1 clr = 1'b1;
        tick();
        chk("r_restart_gnt", 8'(gnt), 8'h2);
        chk("r_restart_q", 8'(q), 8'h1);
        chk("r_restart_vld", 8'(vld), 8'h1);
        tick();
        chk("r_restart_q1", 8'(q), 8'h4);
        req = 2'b00;
        tick();
        chk("r_abort_gnt", 8'(gnt), 8'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
